// File: rtl/fp_mul_pkg.sv
// Shared constants and types for the FP multiply mantissa datapath.
package fp_mul_pkg;

    localparam int MANT_W = 24;
    localparam int PROD_W = 2 * MANT_W;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_t;

    function automatic int calcIter(input int width, input int bitsPerCycle);
        return width / bitsPerCycle;
    endfunction

endpackage

// File: rtl/mant_pp_gen.sv
// Combinational partial product: multiplicand times one small multiplier digit.
module mant_pp_gen
    import fp_mul_pkg::*;
#(
    parameter int WIDTH = MANT_W,
    parameter int BITS  = 2
) (
    input  logic [WIDTH-1:0]      multiplicand,
    input  logic [BITS-1:0]       digit,
    output logic [WIDTH+BITS-1:0] partial
);

    localparam int PP_W = WIDTH + BITS;

    assign partial = PP_W'(multiplicand) * PP_W'(digit);

endmodule

// File: rtl/mantissa_multiplier_seq.sv
// Iterative unsigned mantissa multiplier, BITS_PER_CYCLE multiplier bits per cycle.
// MANT_MUL_ZERO_SKIP_EN: zero operands finish after a single BUSY cycle.
module mantissa_multiplier_seq
    import fp_mul_pkg::*;
#(
    parameter int WIDTH          = MANT_W,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mant_a,
    input  logic [WIDTH-1:0]     mant_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   multiplicationResult
);

    localparam int ITER  = calcIter(WIDTH, BITS_PER_CYCLE);
    localparam int PROD  = 2 * WIDTH;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam int SH_W  = $clog2(PROD);
    localparam int PP_W  = WIDTH + BITS_PER_CYCLE;

    generate
        if (WIDTH % BITS_PER_CYCLE != 0) begin : gBadCfg
            $error("BITS_PER_CYCLE must divide WIDTH");
        end
    endgenerate

    mul_state_t state;
    mul_state_t nextState;

    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [PROD-1:0]  acc;
    logic [PROD-1:0]  sum;
    logic [PROD-1:0]  ppShifted;
    logic [PP_W-1:0]  pp;
    logic [CNT_W-1:0] cnt;
    logic [SH_W-1:0]  shiftAmt;
    logic             accept;
    logic             lastIter;
    logic             zeroOp;

    assign accept   = in_valid && (state == IDLE);
    assign lastIter = (cnt == CNT_W'(ITER - 1));

`ifdef MANT_MUL_ZERO_SKIP_EN
    assign zeroOp = (cnt == '0) && ((opA == '0) || (opB == '0));
`else
    assign zeroOp = 1'b0;
`endif

    mant_pp_gen #(
        .WIDTH (WIDTH),
        .BITS  (BITS_PER_CYCLE)
    ) uPpGen (
        .multiplicand (opA),
        .digit        (opB[BITS_PER_CYCLE-1:0]),
        .partial      (pp)
    );

    // Digit weight grows by BITS_PER_CYCLE each iteration.
    assign shiftAmt  = SH_W'(cnt) * SH_W'(BITS_PER_CYCLE);
    assign ppShifted = PROD'(pp) << shiftAmt;
    assign sum       = acc + ppShifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (in_valid) nextState = BUSY;
            BUSY: if (lastIter || zeroOp) nextState = DONE;
            DONE: if (out_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opA                  <= '0;
            opB                  <= '0;
            acc                  <= '0;
            cnt                  <= '0;
            multiplicationResult <= '0;
        end else if (accept) begin
            opA <= mant_a;
            opB <= mant_b;
            acc <= '0;
            cnt <= '0;
        end else if (state == BUSY) begin
            opB <= opB >> BITS_PER_CYCLE;
            cnt <= cnt + CNT_W'(1);
            acc <= sum;
            if (zeroOp) begin
                multiplicationResult <= '0;
            end else if (lastIter) begin
                multiplicationResult <= sum;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_mantissa_multiplier_seq.sv
// Directed and randomized checks for mantissa_multiplier_seq against a plain
// arithmetic product model with a FIFO scoreboard.
module tb_mantissa_multiplier_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] mant_a;
    logic [23:0] mant_b;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] multiplicationResult;

    int nComp = 0;
    int nErr  = 0;

`ifdef MANT_MUL_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 12;
`endif

    mantissa_multiplier_seq dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .mant_a               (mant_a),
        .mant_b               (mant_b),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .multiplicationResult (multiplicationResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nComp++;
        assert (obs === exp)
        else begin
            nErr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] randOp();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 24'h000000;
        if (sel == 1) return 24'hFFFFFF;
        return 24'($urandom);
    endfunction

    task automatic runOp(input string tag, input logic [23:0] a,
                         input logic [23:0] b, input logic [47:0] exp,
                         input int expLat, input int hold);
        int  lat;
        bit  readyInBusy;
        chk({tag, "_readyPre"}, 64'(in_ready), 64'd1);
        mant_a    = a;
        mant_b    = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        step();
        lat         = 0;
        readyInBusy = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) readyInBusy = 1;
            in_valid = $urandom_range(0, 1) == 1;
            mant_a   = 24'($urandom);
            mant_b   = 24'($urandom);
            step();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(expLat));
        chk({tag, "_readyBusy"}, 64'(readyInBusy), 64'd0);
        chk({tag, "_result"}, 64'(multiplicationResult), 64'(exp));
        in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            mant_a = 24'($urandom);
            step();
            chk({tag, "_holdValid"}, 64'(out_valid), 64'd1);
            chk({tag, "_holdResult"}, 64'(multiplicationResult), 64'(exp));
            chk({tag, "_holdReady"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_relReady"}, 64'(in_ready), 64'd1);
        chk({tag, "_relValid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [47:0] expQ[$];
        logic [47:0] expP;
        int          acceptedN;
        int          deliveredN;
        int          cyc;
        bit          sawValid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mant_a    = '0;
        mant_b    = '0;
        repeat (3) step();
        chk("rstInReady", 64'(in_ready), 64'd1);
        chk("rstOutValid", 64'(out_valid), 64'd0);
        chk("rstResult", 64'(multiplicationResult), 64'd0);
        rst = 1'b0;
        step();

        runOp("t1", 24'h800000, 24'hC00000, 48'h6000_00000000, 12, 0);
        runOp("ones", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 12, 0);
        chk("onesTopBit", 64'(multiplicationResult[47]), 64'd1);
        runOp("bp", 24'h800000, 24'h800000, 48'h4000_00000000, 12, 5);
        runOp("zeroA", 24'h000000, 24'hABCDEF, 48'h0, ZLAT, 0);
        runOp("one", 24'h000001, 24'h000001, 48'h1, 12, 0);
        runOp("zeroB", 24'h123456, 24'h000000, 48'h0, ZLAT, 1);

        // Abort an operation six edges after acceptance.
        mant_a   = 24'hFFFFFF;
        mant_b   = 24'hFFFFFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abortInReady", 64'(in_ready), 64'd1);
        chk("abortOutValid", 64'(out_valid), 64'd0);
        chk("abortResult", 64'(multiplicationResult), 64'd0);
        sawValid  = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) sawValid = 1;
        end
        out_ready = 1'b0;
        chk("abortNoValid", 64'(sawValid), 64'd0);
        expP = 48'(24'h9ABCDE) * 48'(24'h876543);
        runOp("postRst", 24'h9ABCDE, 24'h876543, expP, 12, 2);

        acceptedN  = 0;
        deliveredN = 0;
        cyc        = 0;
        while ((acceptedN < 200 || deliveredN < acceptedN) && cyc < 20000) begin
            in_valid  = (acceptedN < 200) && ($urandom_range(0, 3) != 0);
            mant_a    = randOp();
            mant_b    = randOp();
            out_ready = $urandom_range(0, 2) != 0;
            if (in_valid && in_ready) begin
                expQ.push_back(48'(mant_a) * 48'(mant_b));
                acceptedN++;
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    chk("randSpurious", 64'd1, 64'd0);
                end else begin
                    expP = expQ.pop_front();
                    chk("randProduct", 64'(multiplicationResult), 64'(expP));
                end
                deliveredN++;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("randAccepted", 64'(acceptedN), 64'd200);
        chk("randDelivered", 64'(deliveredN), 64'(acceptedN));
        chk("randQueueEmpty", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nErr);
        $finish;
    end

endmodule
